// File: rtl/sa_pkg.sv
// Shared widths, FSM state encoding and sizing helpers for the systolic GEMM tile.
package sa_pkg;

  localparam int unsigned SA_ROWS  = 4;
  localparam int unsigned SA_COLS  = 4;
  localparam int unsigned SA_A_W   = 9;
  localparam int unsigned SA_B_W   = 8;
  localparam int unsigned SA_ACC_W = 32;
  localparam int unsigned SA_K_W   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } sa_state_e;

  // Cycles needed for the last injected beat to reach the far corner PE.
  function automatic int unsigned flush_len(input int unsigned rows, input int unsigned cols);
    return rows + cols - 1;
  endfunction

endpackage

// File: rtl/sa_pe.sv
// One output-stationary MAC cell: accumulates a*b every cycle, forwards A right and B down.
module sa_pe
  import sa_pkg::*;
#(
  parameter int unsigned A_W   = SA_A_W,
  parameter int unsigned B_W   = SA_B_W,
  parameter int unsigned ACC_W = SA_ACC_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic signed [A_W-1:0]   a_in,
  input  logic signed [B_W-1:0]   b_in,
  output logic signed [A_W-1:0]   a_out,
  output logic signed [B_W-1:0]   b_out,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [A_W+B_W-1:0] prod;

  assign prod = a_in * b_in;

  // Accumulator wraps modulo 2^ACC_W; product is sign-extended by the sized cast.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else begin
      a_out <= a_in;
      b_out <= b_in;
      acc   <= clr ? '0 : acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/sa_tile_engine.sv
// ROWS x COLS output-stationary systolic GEMM tile with input skewing, K-length control
// and row-by-row result drain under backpressure.
module sa_tile_engine
  import sa_pkg::*;
#(
  parameter int unsigned ROWS  = SA_ROWS,
  parameter int unsigned COLS  = SA_COLS,
  parameter int unsigned A_W   = SA_A_W,
  parameter int unsigned B_W   = SA_B_W,
  parameter int unsigned ACC_W = SA_ACC_W,
  parameter int unsigned K_W   = SA_K_W,
  localparam int unsigned RIDX_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [K_W-1:0]          k_len,
  output logic                    busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ROWS*A_W-1:0]     a_vec,
  input  logic [COLS*B_W-1:0]     b_vec,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [COLS*ACC_W-1:0]   out_row,
  output logic [RIDX_W-1:0]       out_row_idx,
  output logic                    done
);

  localparam int unsigned FLUSH_LEN = flush_len(ROWS, COLS);

  sa_state_e        state;
  logic [K_W-1:0]   cnt;
  logic [K_W-1:0]   k_len_q;
  logic             beat_fire;
  logic             tile_clr;

  logic signed [A_W-1:0]   a_inj  [ROWS];
  logic signed [B_W-1:0]   b_inj  [COLS];
  logic signed [A_W-1:0]   a_h    [ROWS][COLS+1];
  logic signed [B_W-1:0]   b_v    [ROWS+1][COLS];
  logic signed [ACC_W-1:0] acc_w  [ROWS][COLS];
  logic [COLS*ACC_W-1:0]   row_flat [ROWS];
  logic [ROWS*A_W-1:0]     a_spill;
  logic [COLS*B_W-1:0]     b_spill;
  logic                    unused_spill;

  // Outside accepted beats the array is fed zeros, so bubbles and flush add nothing.
  assign beat_fire = in_ready && in_valid;
  assign tile_clr  = (state == IDLE) && start && !done;

  for (genvar i = 0; i < ROWS; i++) begin : g_ainj
    assign a_inj[i] = beat_fire ? a_vec[i*A_W +: A_W] : '0;
  end

  for (genvar j = 0; j < COLS; j++) begin : g_binj
    assign b_inj[j] = beat_fire ? b_vec[j*B_W +: B_W] : '0;
  end

  // Row i of A is delayed i cycles before entering column 0.
  for (genvar i = 0; i < ROWS; i++) begin : g_askew
    if (i == 0) begin : g_direct
      assign a_h[i][0] = a_inj[i];
    end else begin : g_delay
      logic signed [A_W-1:0] sr [i];
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int k = 0; k < i; k++) sr[k] <= '0;
        end else begin
          sr[0] <= a_inj[i];
          for (int k = 1; k < i; k++) sr[k] <= sr[k-1];
        end
      end
      assign a_h[i][0] = sr[i-1];
    end
  end

  // Column j of B is delayed j cycles before entering row 0.
  for (genvar j = 0; j < COLS; j++) begin : g_bskew
    if (j == 0) begin : g_direct
      assign b_v[0][j] = b_inj[j];
    end else begin : g_delay
      logic signed [B_W-1:0] sr [j];
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int k = 0; k < j; k++) sr[k] <= '0;
        end else begin
          sr[0] <= b_inj[j];
          for (int k = 1; k < j; k++) sr[k] <= sr[k-1];
        end
      end
      assign b_v[0][j] = sr[j-1];
    end
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      sa_pe #(
        .A_W   (A_W),
        .B_W   (B_W),
        .ACC_W (ACC_W)
      ) u_pe (
        .clk   (clk),
        .reset (reset),
        .clr   (tile_clr),
        .a_in  (a_h[i][j]),
        .b_in  (b_v[i][j]),
        .a_out (a_h[i][j+1]),
        .b_out (b_v[i+1][j]),
        .acc   (acc_w[i][j])
      );
      assign row_flat[i][(COLS-1-j)*ACC_W +: ACC_W] = acc_w[i][j];
    end
    assign a_spill[i*A_W +: A_W] = a_h[i][COLS];
  end

  for (genvar j = 0; j < COLS; j++) begin : g_bspill
    assign b_spill[j*B_W +: B_W] = b_v[ROWS][j];
  end

  assign unused_spill = ^{a_spill, b_spill};

  // Tile control: start -> LOAD (k_len beats) -> FLUSH -> DRAIN (ROWS handshakes) -> IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      k_len_q     <= '0;
      busy        <= 1'b0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_row     <= '0;
      out_row_idx <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !done) begin
            k_len_q     <= k_len;
            cnt         <= '0;
            busy        <= 1'b1;
            out_row     <= '0;
            out_row_idx <= '0;
            if (k_len == '0) begin
              state     <= DRAIN;
              out_valid <= 1'b1;
            end else begin
              state    <= LOAD;
              in_ready <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (in_valid) begin
            if (cnt == k_len_q - K_W'(1)) begin
              state    <= FLUSH;
              in_ready <= 1'b0;
              cnt      <= '0;
            end else begin
              cnt <= cnt + K_W'(1);
            end
          end
        end
        FLUSH: begin
          if (cnt == K_W'(FLUSH_LEN - 1)) begin
            state       <= DRAIN;
            out_valid   <= 1'b1;
            out_row     <= row_flat[0];
            out_row_idx <= '0;
          end else begin
            cnt <= cnt + K_W'(1);
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (out_row_idx == RIDX_W'(ROWS - 1)) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              out_row_idx <= out_row_idx + RIDX_W'(1);
              out_row     <= row_flat[out_row_idx + RIDX_W'(1)];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sa_tile_engine.sv
// Scoreboard bench for sa_tile_engine: a matrix-product model queues expected rows,
// a monitor pops and compares them on every output handshake.
module tb_sa_tile_engine;

  localparam int unsigned ROWS   = 4;
  localparam int unsigned COLS   = 4;
  localparam int unsigned A_W    = 9;
  localparam int unsigned B_W    = 8;
  localparam int unsigned ACC_W  = 32;
  localparam int unsigned K_W    = 16;
  localparam int unsigned RIDX_W = 2;
  localparam int unsigned RW     = COLS * ACC_W;
  localparam int unsigned AV_W   = ROWS * A_W;
  localparam int unsigned BV_W   = COLS * B_W;
  localparam int         MAXK   = 16;

  typedef struct packed {
    logic [RIDX_W-1:0] idx;
    logic [RW-1:0]     row;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [K_W-1:0]    k_len;
  logic              busy;
  logic              in_valid;
  logic              in_ready;
  logic [AV_W-1:0]   a_vec;
  logic [BV_W-1:0]   b_vec;
  logic              out_valid;
  logic              out_ready;
  logic [RW-1:0]     out_row;
  logic [RIDX_W-1:0] out_row_idx;
  logic              done;

  logic ready_man;
  logic rand_ready;
  logic rnd_bit;

  int n_checks;
  int n_pass;
  int hs_count;
  int load_cycles;
  int not_ready;

  int am [MAXK][ROWS];
  int bm [MAXK][COLS];

  exp_t sb [$];

  logic              done_pending;
  logic              prev_hold;
  logic [RW-1:0]     prev_row;
  logic [RIDX_W-1:0] prev_idx;

  sa_tile_engine #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .A_W   (A_W),
    .B_W   (B_W),
    .ACC_W (ACC_W),
    .K_W   (K_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .k_len       (k_len),
    .busy        (busy),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a_vec       (a_vec),
    .b_vec       (b_vec),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_row     (out_row),
    .out_row_idx (out_row_idx),
    .done        (done)
  );

  always #5 clk = ~clk;

  assign out_ready = rand_ready ? rnd_bit : ready_man;

  always @(posedge clk) begin
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: C[r][c] = sum_k A[r][k] * B[k][c], truncated to ACC_W bits.
  task automatic push_expected(input int k);
    exp_t e;
    for (int r = 0; r < ROWS; r++) begin
      e.idx = RIDX_W'(r);
      e.row = '0;
      for (int c = 0; c < COLS; c++) begin
        longint s = 0;
        for (int kk = 0; kk < k; kk++) s += longint'(am[kk][r]) * longint'(bm[kk][c]);
        e.row[(COLS-1-c)*ACC_W +: ACC_W] = ACC_W'(s);
      end
      sb.push_back(e);
    end
  endtask

  task automatic fill_identity();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < ROWS; i++) am[k][i] = (i == k) ? 1 : 0;
      for (int j = 0; j < COLS; j++) bm[k][j] = 4 * k + j + 1;
    end
  endtask

  task automatic fill_random(input int k);
    for (int kk = 0; kk < k; kk++) begin
      for (int i = 0; i < ROWS; i++) am[kk][i] = int'($urandom_range(0, 511)) - 256;
      for (int j = 0; j < COLS; j++) bm[kk][j] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  task automatic start_tile(input int k);
    @(posedge clk); #1;
    start = 1'b1;
    k_len = K_W'(k);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: every cycle valid, 1: bubble first then alternate, 2: random bubbles.
  task automatic feed(input int mode, input int stop_after);
    int idx = 0;
    int cyc = 0;
    bit v;
    load_cycles = 0;
    not_ready   = 0;
    while (idx < stop_after && cyc < 1000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 1);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      in_valid = v;
      if (v) begin
        for (int i = 0; i < ROWS; i++) a_vec[i*A_W +: A_W] = A_W'(am[idx][i]);
        for (int j = 0; j < COLS; j++) b_vec[j*B_W +: B_W] = B_W'(bm[idx][j]);
      end else begin
        a_vec = AV_W'({$urandom(), $urandom()});
        b_vec = BV_W'($urandom());
      end
      @(negedge clk);
      if (in_ready) load_cycles++;
      else not_ready++;
      if (in_ready && in_valid) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    if (idx < stop_after) begin
      n_checks++;
      $display("FAIL feed_timeout: accepted %0d beats, needed %0d", idx, stop_after);
    end
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int c = 0; c < 500 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL done_timeout: done not seen, %0d rows still expected", sb.size());
    end
  endtask

  // Monitor: row compare on handshake, hold-stability under backpressure, done pulse timing.
  always @(negedge clk) begin
    if (reset) begin
      if (done_pending || done) check("done_pulse", RW'(done), RW'(done_pending));
      done_pending = 1'b0;
      if (prev_hold && out_valid) begin
        check("hold_row", out_row, prev_row);
        check("hold_idx", RW'(out_row_idx), RW'(prev_idx));
      end
      if (out_valid && out_ready) begin
        exp_t e;
        hs_count++;
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_row: idx %0d row %h with empty scoreboard", out_row_idx, out_row);
        end else begin
          e = sb.pop_front();
          check("row_data", out_row, e.row);
          check("row_idx", RW'(out_row_idx), RW'(e.idx));
          if (e.idx == RIDX_W'(ROWS - 1)) done_pending = 1'b1;
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_row  = out_row;
      prev_idx  = out_row_idx;
    end else begin
      done_pending = 1'b0;
      prev_hold    = 1'b0;
    end
  end

  initial begin
    int lat;
    int busy_cnt;
    exp_t held;
    n_checks = 0; n_pass = 0; hs_count = 0;
    done_pending = 1'b0; prev_hold = 1'b0; prev_row = '0; prev_idx = '0;
    reset = 1'b0; start = 1'b0; k_len = '0; in_valid = 1'b0;
    a_vec = '0; b_vec = '0; ready_man = 1'b1; rand_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_busy", RW'(busy), RW'(0));
    check("rst_in_ready", RW'(in_ready), RW'(0));
    check("rst_out_valid", RW'(out_valid), RW'(0));
    check("rst_done", RW'(done), RW'(0));
    check("rst_out_row", out_row, RW'(0));
    check("rst_out_idx", RW'(out_row_idx), RW'(0));
    @(posedge clk); #1;
    reset = 1'b1;

    // Identity A, B = 1..16: rows equal B rows; out_valid 8 negedges after the last beat.
    fill_identity();
    hs_count = 0;
    start_tile(4);
    push_expected(4);
    feed(0, 4);
    check("t1_load_cycles", RW'(load_cycles), RW'(4));
    lat = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    check("t1_drain_latency", RW'(lat), RW'(8));
    wait_done();
    check("t1_handshakes", RW'(hs_count), RW'(4));

    // Extremes: (-256)*(-128) = 32768 in every accumulator.
    for (int i = 0; i < ROWS; i++) am[0][i] = -256;
    for (int j = 0; j < COLS; j++) bm[0][j] = -128;
    hs_count = 0;
    start_tile(1);
    push_expected(1);
    feed(0, 1);
    wait_done();
    check("t2_handshakes", RW'(hs_count), RW'(4));

    // Bubbles every other cycle: same result, LOAD spans 8 cycles with in_ready held.
    fill_identity();
    hs_count = 0;
    start_tile(4);
    push_expected(4);
    feed(1, 4);
    check("t3_load_cycles", RW'(load_cycles), RW'(8));
    check("t3_ready_drops", RW'(not_ready), RW'(0));
    @(negedge clk);
    check("t3_ready_after_load", RW'(in_ready), RW'(0));
    wait_done();
    check("t3_handshakes", RW'(hs_count), RW'(4));

    // Backpressure for 5 cycles while row 1 is presented.
    fill_random(4);
    hs_count = 0;
    ready_man = 1'b0;
    start_tile(4);
    push_expected(4);
    feed(0, 4);
    for (int c = 0; c < 50 && !out_valid; c++) begin
      @(posedge clk); #1;
    end
    ready_man = 1'b1;
    @(posedge clk); #1;
    ready_man = 1'b0;
    held = (sb.size() > 0) ? sb[0] : '0;
    repeat (5) begin
      @(negedge clk);
      check("t4_bp_valid", RW'(out_valid), RW'(1));
      check("t4_bp_idx", RW'(out_row_idx), RW'(1));
      check("t4_bp_row", out_row, held.row);
    end
    @(posedge clk); #1;
    ready_man = 1'b1;
    wait_done();
    check("t4_handshakes", RW'(hs_count), RW'(4));
    check("t4_sb_empty", RW'(sb.size()), RW'(0));

    // Reset after 2 beats aborts; the next identity tile must be exact.
    fill_random(4);
    start_tile(4);
    feed(0, 2);
    reset = 1'b0;
    #1;
    check("t5_abort_busy", RW'(busy), RW'(0));
    check("t5_abort_in_ready", RW'(in_ready), RW'(0));
    check("t5_abort_out_valid", RW'(out_valid), RW'(0));
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    fill_identity();
    hs_count = 0;
    start_tile(4);
    push_expected(4);
    feed(0, 4);
    wait_done();
    check("t5_handshakes", RW'(hs_count), RW'(4));

    // k_len = 0: four zero rows; start held through DRAIN and the done cycle is ignored.
    hs_count = 0;
    start_tile(0);
    push_expected(0);
    @(negedge clk);
    check("t6_valid_after_start", RW'(out_valid), RW'(1));
    start = 1'b1;
    k_len = K_W'(2);
    wait_done();
    @(posedge clk); #1;
    start = 1'b0;
    busy_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (busy || out_valid) busy_cnt++;
    end
    check("t6_no_second_tile", RW'(busy_cnt), RW'(0));
    check("t6_handshakes", RW'(hs_count), RW'(4));

    // Random tiles with random bubbles and random downstream readiness.
    rand_ready = 1'b1;
    for (int t = 0; t < 15; t++) begin
      int k;
      k = int'($urandom_range(1, MAXK));
      fill_random(k);
      hs_count = 0;
      start_tile(k);
      push_expected(k);
      feed(2, k);
      wait_done();
      check("rand_handshakes", RW'(hs_count), RW'(4));
    end
    rand_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("final_sb_empty", RW'(sb.size()), RW'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
